// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefDataW = 32;

    // Which requester owns the read response due next cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND_I = 2'd1,
        PEND_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles a pending fetch lost arbitration.
module arb_wait_counter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CNT_W    = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != MaxVal)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory with a
// one-cycle registered read; data has priority until a fetch has starved.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CntW = ($clog2(MAX_WAIT + 1) < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxVal = CntW'(MAX_WAIT);

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [CntW-1:0] wait_cnt;
    logic            wait_inc;
    logic            wait_clear;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CntW)
    ) u_wait_counter (
        .clk   (clk),
        .clr   (clr),
        .inc   (wait_inc),
        .clear (wait_clear),
        .count (wait_cnt)
    );

    assign wait_inc   = if_req & ~if_gnt;
    assign wait_clear = if_gnt | ~if_req;

    // Grants are gated by clr so nothing issues while reset is held.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!clr) begin
            if (if_req && (!d_req || (wait_cnt == MaxVal))) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_wen   = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (if_gnt) begin
            state_d = PEND_I;
        end else if (d_gnt && !d_we) begin
            state_d = PEND_D;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Gated by clr as well: the first clr cycle may still see a stale state_q.
    always_comb begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        if (!clr) begin
            if (state_q == PEND_I) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else if (state_q == PEND_D) begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed checks of memory_arbiter against a transaction-level model.
module tb_memory_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 3;

    logic          clk = 1'b0;
    logic          clr;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          mem_en, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_init;

    memory_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        if (i == 4) return 32'h20080005;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Environment memory: one-cycle registered read.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (mem_en) begin
            if (mem_wen) mem[mem_addr] <= mem_wdata;
            else         mem_rdata <= mem[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: starvation age, expected next response, shadow memory.
    int            starve = 0;
    int            pend = 0;          // 0 none, 1 fetch, 2 data
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] shadow [256];
    logic          last_ig, last_dg;

    task automatic step(input logic c, input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] wd);
        logic          e_ig, e_dg, e_irv, e_drv;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        clr = c; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
        #1;
        e_ig   = !c && ir && (!dr || starve == MW);
        e_dg   = !c && dr && !e_ig;
        e_addr = e_ig ? ia : (e_dg ? da : '0);
        e_irv  = !c && pend == 1;
        e_drv  = !c && pend == 2;
        check_eq("if_gnt", if_gnt, e_ig);
        check_eq("d_gnt", d_gnt, e_dg);
        check_eq("mem_en", mem_en, e_ig || e_dg);
        check_eq("mem_wen", mem_wen, e_dg && dw);
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wdata", mem_wdata, e_dg ? wd : '0);
        check_eq("if_rvalid", if_rvalid, e_irv);
        check_eq("if_rdata", if_rdata, e_irv ? pend_data : '0);
        check_eq("d_rvalid", d_rvalid, e_drv);
        check_eq("d_rdata", d_rdata, e_drv ? pend_data : '0);
        check_eq("rvalid_excl", if_rvalid && d_rvalid, 1'b0);
        last_ig = e_ig;
        last_dg = e_dg;
        if (c) begin
            starve = 0;
            pend   = 0;
        end else begin
            starve = (ir && !e_ig) ? ((starve < MW) ? starve + 1 : MW) : 0;
            pend   = 0;
            if (e_ig) begin
                pend = 1; pend_data = shadow[ia];
            end else if (e_dg && !dw) begin
                pend = 2; pend_data = shadow[da];
            end
            if (e_dg && dw) shadow[da] = wd;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    logic          r_ir, r_dr, r_dw;
    logic [AW-1:0] r_ia, r_da;
    logic [DW-1:0] r_wd;
    logic [3:0]    dg_hist;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        clr = 1'b1; mem_init = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 32'h12345678);
        mem_init = 1'b0;
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h22, 32'h0);
        idle();

        // Fetch only.
        step(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, '0, '0);
        check_eq("fetch_addr", mem_addr, 8'h04);
        idle();
        check_eq("fetch_rdata", if_rdata, 32'h20080005);

        // Data write, then read it back.
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        check_eq("wr_wdata", mem_wdata, 32'hDEADBEEF);
        idle();
        check_eq("wr_no_rvalid", d_rvalid, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h10, '0);
        idle();
        check_eq("wr_readback", d_rdata, 32'hDEADBEEF);

        // Contention: data wins three times, then the fetch.
        dg_hist = '0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 8'h40, '0);
            dg_hist[k] = d_gnt;
        end
        check_eq("contention_pattern", dg_hist, 4'b0111);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h41, '0);
        idle();

        // Back-to-back fetch then data read.
        step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h06, '0);
        idle();
        idle();

        // Reset during a pending data read.
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h07, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        idle();
        check_eq("clr_discard", d_rvalid, 1'b0);

        // Withdrawn fetch: age must restart, so data again wins three times.
        step(1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 8'h09, '0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        dg_hist = '0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 8'h0B, '0);
            dg_hist[k] = d_gnt;
        end
        check_eq("withdraw_age", dg_hist, 4'b0111);
        idle();

        // Randomized traffic obeying hold-until-grant, with occasional withdraw and clr.
        r_ir = 1'b0; r_dr = 1'b0; r_dw = 1'b0; r_ia = '0; r_da = '0; r_wd = '0;
        last_ig = 1'b0; last_dg = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!r_ir || last_ig) begin
                r_ir = 1'($urandom_range(0, 1));
                r_ia = 8'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                r_ir = 1'b0;
            end
            if (!r_dr || last_dg) begin
                r_dr = 1'($urandom_range(0, 1));
                r_dw = 1'($urandom_range(0, 1));
                r_da = 8'($urandom_range(0, 31));
                r_wd = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                r_dr = 1'b0;
            end
            step(($urandom_range(0, 99) == 0), r_ir, r_ia, r_dr, r_dw, r_da, r_wd);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 3, maximum consecutive cycles a pending fetch may lose arbitration.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port if_req  input  1  instruction-fetch read request.
REQ-007 The block SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-008 The block SHALL have port if_gnt  output  1  fetch command issued this cycle.
REQ-009 The block SHALL have port if_rvalid  output  1  fetch read data valid.
REQ-010 The block SHALL have port if_rdata  output  DATA_W  fetch read data.
REQ-011 The block SHALL have port d_req  input  1  data-port request.
REQ-012 The block SHALL have port d_we  input  1  data-port write (1) / read (0).
REQ-013 The block SHALL have port d_addr  input  ADDR_W  data-port address.
REQ-014 The block SHALL have port d_wdata  input  DATA_W  data-port write data.
REQ-015 The block SHALL have port d_gnt  output  1  data command issued this cycle.
REQ-016 The block SHALL have port d_rvalid  output  1  data read data valid.
REQ-017 The block SHALL have port d_rdata  output  DATA_W  data read data.
REQ-018 The block SHALL have ports mem_en, mem_wen (output 1), mem_addr (output ADDR_W), mem_wdata (output DATA_W), mem_rdata (input DATA_W) to one shared memory_unit with one-cycle registered read latency.

Function
REQ-019 Requesters SHALL hold req, addr, we, wdata stable until gnt; req may drop without gnt, and no command SHALL then issue.
REQ-020 At most one of if_gnt/d_gnt SHALL be high per cycle; gnt is combinational from current req and registered state.
REQ-021 Priority: d_req wins unless wait_cnt == MAX_WAIT and if_req is high, in which case if_req wins.
REQ-022 wait_cnt SHALL increment (saturating at MAX_WAIT) each cycle if_req is high without if_gnt, and clear to 0 on if_gnt or when if_req is low.
REQ-023 In a grant cycle: mem_en=1, mem_addr=granted address, mem_wen=d_we for data grant else 0, mem_wdata=d_wdata for data grant else 0; with no grant mem_en=mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-024 FSM states IDLE, PEND_I, PEND_D track the outstanding read response; next state = PEND_I after fetch grant, PEND_D after data read grant, IDLE otherwise (including data write grant).
REQ-025 In PEND_I, if_rvalid=1 and if_rdata=mem_rdata; in PEND_D, d_rvalid=1 and d_rdata=mem_rdata; rdata SHALL be 0 whenever its rvalid is 0.
REQ-026 A new grant SHALL be allowed in the same cycle as an rvalid (back-to-back, one command per cycle throughput).
REQ-027 A data write completes at d_gnt; no d_rvalid SHALL follow a write.
REQ-028 Read latency SHALL be exactly one cycle from gnt to rvalid.

Reset
REQ-029 While clr is high: state=IDLE, wait_cnt=0, all gnt, rvalid, mem_en, mem_wen outputs 0, all data/address outputs 0.
REQ-030 clr asserted while a read is pending SHALL discard it; no rvalid SHALL appear in the cycle after clr deasserts.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum (IDLE, PEND_I, PEND_D) and default ADDR_W/DATA_W constants.
REQ-032 The saturating starvation counter SHALL be sub-module arb_wait_counter (inputs clk, clr, inc, clear; output count).

Verification
REQ-033 Fetch only: if_req=1, if_addr=8'h04, mem_rdata next cycle 32'h20080005 -> if_gnt cycle 0, mem_addr=8'h04, if_rvalid cycle 1 with if_rdata=32'h20080005.
REQ-034 Data write: d_req=1, d_we=1, d_addr=8'h10, d_wdata=32'hDEADBEEF -> d_gnt, mem_wen=1, mem_wdata=32'hDEADBEEF same cycle; d_rvalid stays 0.
REQ-035 Contention: if_req and d_req (reads) held continuously, MAX_WAIT=3 -> d_gnt cycles 0,1,2, if_gnt cycle 3; responses alternate correctly one cycle later.
REQ-036 Back-to-back: fetch grant cycle 0, data read grant cycle 1 -> if_rvalid cycle 1, d_rvalid cycle 2, never both high.
REQ-037 Reset mid-read: d_gnt read at cycle 0, clr=1 cycle 1 -> d_rvalid=0 cycle 1 and cycle 2, state IDLE.
REQ-038 Request withdrawn: if_req high one cycle while d_req wins, then low -> no if_gnt, wait_cnt returns to 0.
